// File: rtl/heu_if_pkg.sv
// Shared window geometry and tx FSM encoding for the IPGU->HEU window link.
// No logic: constants and types only.
// No handshake: imported by the window transmitter and the HEU.
package heu_if_pkg;
    localparam int ROWS      = 5;
    localparam int COLS      = 80;
    localparam int DATA_W    = 8;
    localparam int WIN_BYTES = ROWS * COLS;
    localparam int PTR_W     = $clog2(WIN_BYTES);

    typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT_LO,
        WAIT_HI
    } tx_state_t;
endpackage

// File: rtl/heu_window_tx_if.sv
// Pixel stream in, window plus strobe out, HEU idle flag back.
// Wires only, no latency.
// pix_ready is the only backpressure toward the pixel source.
interface heu_window_tx_if;
    import heu_if_pkg::*;

    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              heu_in_ready;
    logic              out_ready;
    window_t           q;

    modport master (
        input  pix_valid, pix_data, heu_in_ready,
        output pix_ready, out_ready, q
    );

    modport slave (
        output pix_valid, pix_data, heu_in_ready,
        input  pix_ready, out_ready, q
    );
endinterface

// File: rtl/heu_window_tx_bank.sv
// One window-sized byte register, written one byte at a time by linear index.
// Write visible on win the cycle after we.
// No backpressure: the caller decides when we may be asserted.
module window_bank
    import heu_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PTR_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output window_t           win
);

    // Row-major decode: index r*COLS+c lands in row r, column c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (we) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (idx == PTR_W'(r * COLS + c)) begin
                        win[r][c] <= din;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/heu_window_tx.sv
// Double-buffered 5x80 pixel window collector driving the HEU d bus and ipgu_out_ready strobe.
// Strobe is high in the second cycle after the final byte of a window is accepted (HEU idle).
// pix_ready drops while the bank being written is still owned by the HEU; q is held until release.
module heu_window_tx
    import heu_if_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    heu_window_tx_if.master bus
);

    logic [PTR_W-1:0] ptr;
    logic             wbank;
    logic             rbank;
    logic [1:0]       full;
    logic [1:0]       full_n;
    tx_state_t        state;
    tx_state_t        state_n;
    logic             accept;
    logic             last;
    logic             rel;
    window_t          win0;
    window_t          win1;

    assign bus.pix_ready = ~full[wbank];
    assign accept        = bus.pix_valid & ~full[wbank];
    assign last          = accept && (ptr == PTR_W'(WIN_BYTES - 1));

    window_bank u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept & ~wbank),
        .idx   (ptr),
        .din   (bus.pix_data),
        .win   (win0)
    );

    window_bank u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept & wbank),
        .idx   (ptr),
        .din   (bus.pix_data),
        .win   (win1)
    );

    assign bus.q         = rbank ? win1 : win0;
    assign bus.out_ready = (state == FIRE);

    // Fill completion and release always touch different banks, so both may land together.
    always_comb begin
        full_n = full;
        if (last) full_n[wbank] = 1'b1;
        if (rel)  full_n[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
            state <= IDLE;
        end else begin
            if (accept) ptr <= last ? '0 : ptr + 1'b1;
            if (last)   wbank <= ~wbank;
            if (rel)    rbank <= ~rbank;
            full  <= full_n;
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        rel     = 1'b0;
        case (state)
            IDLE:    if (full[rbank] && bus.heu_in_ready) state_n = FIRE;
            FIRE:    state_n = WAIT_LO;
            WAIT_LO: if (!bus.heu_in_ready) state_n = WAIT_HI;
            WAIT_HI: begin
                if (bus.heu_in_ready) begin
                    rel     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_heu_window_tx.sv
// Directed bench for heu_window_tx: table of expected window bytes plus multi-cycle sequences.
module tb_heu_window_tx;
    import heu_if_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    heu_window_tx_if bus ();

    heu_window_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int ncyc       = 0;
    int strobes    = 0;
    int strobe_n   = 0;
    int last_acc_n = 0;

    // Strobe counter, sampled on the falling edge away from state updates.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (bus.out_ready === 1'b1) begin
            strobes  = strobes + 1;
            strobe_n = ncyc;
        end
    end

    typedef struct {
        int         k;
        logic [7:0] exp;
    } vec_t;

    vec_t tab_a [8];
    vec_t tab_b [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called and returns at posedge+1; leaves pix_valid low.
    task automatic push(input logic [7:0] d, input int max_wait, output bit ok);
        ok = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (bus.pix_ready === 1'b1) begin
                ok         = 1'b1;
                last_acc_n = ncyc;
            end
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic push_range(input int first, input int n, input int idle_pct, output int rej);
        bit ok;
        rej = 0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 20 && $urandom_range(0, 99) < idle_pct; g++) begin
                @(posedge clk);
                #1;
            end
            push(8'(first + k), 50, ok);
            if (!ok) rej++;
        end
    endtask

    task automatic wait_strobe(input int prev, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (strobes > prev) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_table(input string tag, input int sel);
        if (sel == 0) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_k%0d", tag, tab_a[i].k),
                    bus.q[tab_a[i].k / COLS][tab_a[i].k % COLS], tab_a[i].exp);
        end else begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("%s_k%0d", tag, tab_b[i].k),
                    bus.q[tab_b[i].k / COLS][tab_b[i].k % COLS], tab_b[i].exp);
        end
    endtask

    initial begin
        int  rej;
        int  s0;
        bit  seen;
        bit  ok;
        bit  any_high;

        // Window of bytes k%256: index k -> expected byte.
        tab_a[0] = '{0,   8'd0};
        tab_a[1] = '{1,   8'd1};
        tab_a[2] = '{80,  8'd80};
        tab_a[3] = '{159, 8'd159};
        tab_a[4] = '{255, 8'd255};
        tab_a[5] = '{256, 8'd0};
        tab_a[6] = '{320, 8'd64};
        tab_a[7] = '{399, 8'd143};
        // Window of bytes (400+k)%256.
        tab_b[0] = '{0,   8'd144};
        tab_b[1] = '{80,  8'd224};
        tab_b[2] = '{111, 8'd255};
        tab_b[3] = '{112, 8'd0};
        tab_b[4] = '{240, 8'd128};
        tab_b[5] = '{399, 8'd31};

        rst_n            = 1'b0;
        bus.pix_valid    = 1'b0;
        bus.pix_data     = '0;
        bus.heu_in_ready = 1'b0;
        #3;
        chk("reset_out_ready", bus.out_ready, 0);
        chk("reset_pix_ready", bus.pix_ready, 1);
        chk("reset_q_nonzero", |bus.q, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Partial window then asynchronous reset
        push_range(0, 100, 0, rej);
        chk("partial_q_0_5", bus.q[0][5], 5);
        chk("partial_q_1_19", bus.q[1][19], 99);
        rst_n = 1'b0;
        #2;
        chk("midrst_pix_ready", bus.pix_ready, 1);
        chk("midrst_out_ready", bus.out_ready, 0);
        chk("midrst_q_nonzero", |bus.q, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single back-to-back window with HEU idle
        s0 = strobes;
        bus.heu_in_ready = 1'b1;
        push_range(0, 400, 0, rej);
        chk("win1_rejects", rej, 0);
        wait_strobe(s0, 10, seen);
        bus.heu_in_ready = 1'b0;
        chk("win1_strobe_seen", seen, 1);
        chk("win1_latency", strobe_n - last_acc_n, 3);
        repeat (5) @(posedge clk);
        #1;
        chk("win1_one_strobe", strobes - s0, 1);
        check_table("win1", 0);

        // Second window streams while HEU holds in_ready low
        push_range(400, 400, 0, rej);
        chk("hold_rejects", rej, 0);
        chk("hold_q_0_0", bus.q[0][0], 0);
        chk("hold_q_4_79", bus.q[4][79], 143);
        chk("hold_no_strobe", strobes - s0, 1);
        chk("both_full_pix_ready", bus.pix_ready, 0);
        push(8'hAA, 20, ok);
        chk("extra_byte_accepted", ok, 0);

        bus.heu_in_ready = 1'b1;
        wait_strobe(s0 + 1, 20, seen);
        bus.heu_in_ready = 1'b0;
        chk("win2_strobe_seen", seen, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("win2_one_strobe", strobes - s0, 2);
        check_table("win2", 1);
        chk("bank_free_pix_ready", bus.pix_ready, 1);

        // Bursty fill of the freed bank, released afterwards
        push_range(0, 400, 70, rej);
        chk("burst_rejects", rej, 0);
        chk("burst_no_strobe", strobes - s0, 2);
        chk("burst_full_pix_ready", bus.pix_ready, 0);
        bus.heu_in_ready = 1'b1;
        wait_strobe(s0 + 2, 20, seen);
        bus.heu_in_ready = 1'b0;
        chk("burst_strobe_seen", seen, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("burst_one_strobe", strobes - s0, 3);
        check_table("burst", 0);

        // HEU never comes back: other bank fills, then everything stalls
        push_range(800, 400, 0, rej);
        chk("stuck_rejects", rej, 0);
        any_high = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.pix_ready !== 1'b0) any_high = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("stuck_pix_ready_high", any_high, 0);
        chk("stuck_no_strobe", strobes - s0, 3);
        chk("stuck_q_0_0", bus.q[0][0], 0);
        chk("stuck_q_4_79", bus.q[4][79], 143);

        rst_n = 1'b0;
        #2;
        chk("final_rst_pix_ready", bus.pix_ready, 1);
        chk("final_rst_q_nonzero", |bus.q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/heu_window_tx.md
Name: heu_window_tx

Overview:
Transmit side of the IPGU→HEU window interface. Collects a serial pixel byte stream into a 5x80 (400-byte) window and presents it to the HEU on its d bus with a one-cycle out_ready strobe, holding the window stable until the HEU is finished with it. Double-buffered, so the next window fills while the HEU processes the current one. Sits at the IPGU output and drives the HEU's ipgu_out_ready and d inputs.

Parameters:
ROWS, 5, window rows (HEU d first dimension)
COLS, 80, bytes per row (HEU d second dimension)
DATA_W, 8, pixel width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  upstream byte valid
pix_data  in  DATA_W  upstream pixel byte
pix_ready  out  1  byte accepted when pix_valid & pix_ready at posedge
heu_in_ready  in  1  HEU idle and able to take a window
out_ready  out  1  one-cycle strobe to HEU ipgu_out_ready: window on q is valid
q  out  [ROWS-1:0][COLS-1:0] x DATA_W  window to HEU d

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_ready=0, pix_ready=1, both banks zeroed (q=0), write ptr=0, wbank=rbank=0, full[1:0]=0, tx FSM=IDLE.
- Byte order: k-th accepted byte of a window (k=0..399) goes to row k/COLS, column k%COLS (row-major, row 0 first).
- Fill side: pix_ready = !full[wbank]. On accept, write bank[wbank][ptr]. When ptr==ROWS*COLS-1 is accepted: full[wbank]<=1, wbank toggles, ptr<=0; otherwise ptr++. pix_valid gaps allowed; ptr holds.
- q always drives bank[rbank].
- Tx FSM:
  IDLE: if full[rbank] & heu_in_ready -> FIRE.
  FIRE: out_ready=1 for exactly this cycle -> WAIT_LO.
  WAIT_LO: wait heu_in_ready==0 -> WAIT_HI.
  WAIT_HI: wait heu_in_ready==1 -> release: full[rbank]<=0, rbank toggles -> IDLE.
- Protocol rule: HEU drops in_ready within 1 cycle of the strobe and holds it low while it still reads d; q for the active bank never changes from FIRE until release.
- Latency: final byte accepted at edge N with HEU idle and FSM in IDLE -> out_ready high in cycle N+1 to N+2 (strobe follows the edge after full is set).
- heu_in_ready=0 in IDLE: no strobe; window waits indefinitely.
- Both banks full: pix_ready=0 until release.
- Simultaneous fill-complete on wbank and release of rbank in the same cycle: both updates take effect (different bits of full).
- Release and immediately full next bank: IDLE re-evaluates the cycle after release; minimum 1 idle cycle between strobes.
- Reset mid-operation: all state returns to reset values immediately; partial window discarded; out_ready deasserts asynchronously.

Decomposition:
- Package heu_if_pkg: ROWS, COLS, DATA_W, WIN_BYTES=ROWS*COLS, PTR_W=$clog2(WIN_BYTES), typedef window_t ([ROWS-1:0][COLS-1:0][DATA_W-1:0]), enum tx_state_t {IDLE, FIRE, WAIT_LO, WAIT_HI}. Shared with heu.
- Sub-module window_bank: one window_t register with async clear, write-enable and linear byte index -> row/col decode; instantiated twice.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_ready=0, pix_ready=1, q all 0, next window starts at q[0][0].
- Single window: heu_in_ready=1, bytes k%256 for k=0..399 back-to-back -> exactly one out_ready pulse one cycle after final accept; q[0][0]=0, q[1][0]=80, q[4][79]=143.
- Backpressure: heu_in_ready=0, offer 801 bytes -> no strobe, pix_ready=0 after byte 800 accepted, byte 801 not accepted.
- Hold/double-buffer: after strobe, HEU drops in_ready for 50 cycles while bytes 400..799 stream -> q unchanged; on in_ready rising, exactly one second strobe, q[0][0]=400%256=144.
- Bursty input: pix_valid random 30% duty -> window content identical to back-to-back case, one strobe per 400 accepts.
- Stuck HEU: in_ready never returns high after strobe -> no further strobes, both banks fill, pix_ready=0 steady.
